// File: rtl/acct_gate.sv
// acct_gate: access-control gate between one upstream requester and one downstream port.
// Each request picks a peripheral slot from a 4-bit index field in its address. A per-slot
// permission nibble decides whether the request is forwarded or answered with an error.
// Only one transaction can be in flight at a time.
//
// Ports
//   clk_i, rst_i        : clock, synchronous active-high reset
//   acc_ctrl_i          : per-slot permission nibble {ignored[1:0], write, read}
//   req_*               : upstream request (valid/ready)
//   dn_req_*, dn_*      : downstream request (valid/ready) with latched fields
//   dn_rsp_*            : downstream response, taken only while waiting for it
//   rsp_*               : upstream response (valid/ready)
//   viol_o/_cnt_o/_addr_o : denial pulse, saturating denial count, last denied address
module acct_gate #(
    parameter int unsigned NB_PERIPHERALS = 9,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned PERIPH_SHIFT   = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [4*NB_PERIPHERALS-1:0]   acc_ctrl_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]     req_addr_i,
    input  logic                          req_we_i,
    input  logic [AXI_DATA_WIDTH-1:0]     req_wdata_i,
    output logic                          dn_req_valid_o,
    input  logic                          dn_req_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]     dn_addr_o,
    output logic                          dn_we_o,
    output logic [AXI_DATA_WIDTH-1:0]     dn_wdata_o,
    input  logic                          dn_rsp_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]     dn_rsp_rdata_i,
    input  logic                          dn_rsp_err_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          viol_o,
    output logic [15:0]                   viol_cnt_o,
    output logic [AXI_ADDR_WIDTH-1:0]     viol_addr_o
);

    typedef enum logic [2:0] {StIdle, StFwd, StWaitRsp, StDeny, StRsp} state_e;

    state_e                      state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                        we_q, we_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                        err_q, err_d;
    logic [15:0]                 viol_cnt_q, viol_cnt_d;
    logic [AXI_ADDR_WIDTH-1:0]   viol_addr_q, viol_addr_d;

    logic [3:0] idx;
    logic       permit;

    // Permission lookup on the live request; only used in the acceptance cycle, so later
    // acc_ctrl_i changes cannot affect a transaction already in flight.
    always_comb begin
        idx    = req_addr_i[PERIPH_SHIFT+3:PERIPH_SHIFT];
        permit = 1'b0;
        for (int p = 0; p < int'(NB_PERIPHERALS); p++) begin
            if (int'(idx) == p) begin
                permit = req_we_i ? acc_ctrl_i[4*p+1] : acc_ctrl_i[4*p];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        viol_cnt_d  = viol_cnt_q;
        viol_addr_d = viol_addr_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    wdata_d = req_wdata_i;
                    state_d = permit ? StFwd : StDeny;
                end
            end
            StFwd: begin
                if (dn_req_ready_i) state_d = StWaitRsp;
            end
            StWaitRsp: begin
                if (dn_rsp_valid_i) begin
                    rdata_d = dn_rsp_rdata_i;
                    err_d   = dn_rsp_err_i;
                    state_d = StRsp;
                end
            end
            StDeny: begin
                rdata_d     = '0;
                err_d       = 1'b1;
                viol_addr_d = addr_q;
                if (viol_cnt_q != 16'hFFFF) viol_cnt_d = viol_cnt_q + 16'd1;
                state_d     = StRsp;
            end
            StRsp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            viol_cnt_q  <= '0;
            viol_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            viol_cnt_q  <= viol_cnt_d;
            viol_addr_q <= viol_addr_d;
        end
    end

    // Handshake outputs are held low while reset is asserted so that neither side can
    // complete a handshake that the reset is about to discard.
    always_comb begin
        req_ready_o    = (state_q == StIdle) && !rst_i;
        dn_req_valid_o = (state_q == StFwd) && !rst_i;
        rsp_valid_o    = (state_q == StRsp) && !rst_i;
        viol_o         = (state_q == StDeny) && !rst_i;
        dn_addr_o      = dn_req_valid_o ? addr_q : '0;
        dn_we_o        = dn_req_valid_o ? we_q : 1'b0;
        dn_wdata_o     = dn_req_valid_o ? wdata_q : '0;
        rsp_rdata_o    = rsp_valid_o ? rdata_q : '0;
        rsp_err_o      = rsp_valid_o ? err_q : 1'b0;
        viol_cnt_o     = viol_cnt_q;
        viol_addr_o    = viol_addr_q;
    end

endmodule

// File: tb/tb_acct_gate.sv
module tb_acct_gate;

    localparam int NB = 9;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int PS = 12;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [4*NB-1:0] acc_ctrl;
    logic            req_valid, req_ready, req_we;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic            dn_req_valid, dn_req_ready, dn_we;
    logic [AW-1:0]   dn_addr;
    logic [DW-1:0]   dn_wdata;
    logic            dn_rsp_valid, dn_rsp_err;
    logic [DW-1:0]   dn_rsp_rdata;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic            viol;
    logic [15:0]     viol_cnt;
    logic [AW-1:0]   viol_addr;

    always #5 clk = ~clk;

    acct_gate #(
        .NB_PERIPHERALS(NB),
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .PERIPH_SHIFT  (PS)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .acc_ctrl_i    (acc_ctrl),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_we_i      (req_we),
        .req_wdata_i   (req_wdata),
        .dn_req_valid_o(dn_req_valid),
        .dn_req_ready_i(dn_req_ready),
        .dn_addr_o     (dn_addr),
        .dn_we_o       (dn_we),
        .dn_wdata_o    (dn_wdata),
        .dn_rsp_valid_i(dn_rsp_valid),
        .dn_rsp_rdata_i(dn_rsp_rdata),
        .dn_rsp_err_i  (dn_rsp_err),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .viol_o        (viol),
        .viol_cnt_o    (viol_cnt),
        .viol_addr_o   (viol_addr)
    );

    typedef struct {
        logic [4*NB-1:0] acc;
        logic [AW-1:0]   addr;
        logic            we;
        logic [DW-1:0]   wdata;
        logic [DW-1:0]   dn_rdata;
        logic            dn_err;
        logic            exp_permit;
        logic [DW-1:0]   exp_rdata;
        logic            exp_err;
    } vec_t;

    vec_t        vecs[10];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt;
    logic [AW-1:0] exp_vaddr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic count_denial(input logic [AW-1:0] a);
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        exp_vaddr = a;
    endtask

    // Full transaction starting from an IDLE cycle (called right after a negedge).
    task automatic run_txn(input vec_t v, input int stall);
        acc_ctrl  = v.acc;
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_we    = v.we;
        req_wdata = v.wdata;
        #1;
        chk("idle_ready", 64'(req_ready), 64'(1));
        chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_wdata = '0;
        acc_ctrl  = ~v.acc;
        #1;
        chk("busy_ready", 64'(req_ready), 64'(0));
        if (v.exp_permit) begin
            chk("fwd_valid", 64'(dn_req_valid), 64'(1));
            chk("fwd_addr", dn_addr, v.addr);
            chk("fwd_we", 64'(dn_we), 64'(v.we));
            chk("fwd_wdata", dn_wdata, v.wdata);
            chk("fwd_viol", 64'(viol), 64'(0));
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                acc_ctrl = '0;
                #1;
                chk("stall_valid", 64'(dn_req_valid), 64'(1));
                chk("stall_addr", dn_addr, v.addr);
                chk("stall_wdata", dn_wdata, v.wdata);
            end
            dn_req_ready = 1'b1;
            @(negedge clk);
            dn_req_ready = 1'b0;
            dn_rsp_valid = 1'b1;
            dn_rsp_rdata = v.dn_rdata;
            dn_rsp_err   = v.dn_err;
            #1;
            chk("wait_dn_valid", 64'(dn_req_valid), 64'(0));
            chk("wait_dn_addr", dn_addr, 64'(0));
            chk("wait_rsp_valid", 64'(rsp_valid), 64'(0));
            @(negedge clk);
            dn_rsp_valid = 1'b0;
            dn_rsp_rdata = '0;
            dn_rsp_err   = 1'b0;
        end else begin
            chk("deny_dn_valid", 64'(dn_req_valid), 64'(0));
            chk("deny_dn_addr", dn_addr, 64'(0));
            chk("deny_viol", 64'(viol), 64'(1));
            chk("deny_rsp_valid", 64'(rsp_valid), 64'(0));
            @(negedge clk);
            count_denial(v.addr);
        end
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_err", 64'(rsp_err), 64'(v.exp_err));
        chk("rsp_viol", 64'(viol), 64'(0));
        chk("viol_cnt", 64'(viol_cnt), 64'(exp_cnt));
        chk("viol_addr", viol_addr, exp_vaddr);
        @(negedge clk);
        #1;
        chk("rsp_hold_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_hold_rdata", rsp_rdata, v.exp_rdata);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("post_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("post_rsp_rdata", rsp_rdata, 64'(0));
        chk("post_rsp_err", 64'(rsp_err), 64'(0));
        chk("post_ready", 64'(req_ready), 64'(1));
    endtask

    vec_t tmp;

    initial begin
        //                acc              addr                      we    wdata                     dn_rdata                  dn_err permit exp_rdata                 exp_err
        vecs[0] = '{36'hF_FFFF_FFFF, 64'h2010,                 1'b0, 64'h0,                    64'hDEAD_BEEF,            1'b0, 1'b1, 64'hDEAD_BEEF,            1'b0};
        vecs[1] = '{36'h0_0000_1000, 64'h3008,                 1'b1, 64'hA5A5,                 64'h0,                    1'b0, 1'b0, 64'h0,                    1'b1};
        vecs[2] = '{36'h0_0000_1000, 64'h3010,                 1'b0, 64'h0,                    64'h1234,                 1'b1, 1'b1, 64'h1234,                 1'b1};
        vecs[3] = '{36'hF_FFFF_FFFF, 64'h9000,                 1'b0, 64'h0,                    64'h0,                    1'b0, 1'b0, 64'h0,                    1'b1};
        vecs[4] = '{36'hF_FFFF_FFFF, 64'hFFFF_0000_0000_F123,  1'b1, 64'h77,                   64'h0,                    1'b0, 1'b0, 64'h0,                    1'b1};
        vecs[5] = '{36'hD_FFFF_FFFF, 64'h8000,                 1'b1, 64'h55,                   64'h0,                    1'b0, 1'b0, 64'h0,                    1'b1};
        vecs[6] = '{36'h2_0000_0000, 64'h8040,                 1'b1, 64'hCAFE_F00D_0000_0001,  64'h0,                    1'b0, 1'b1, 64'h0,                    1'b0};
        vecs[7] = '{36'h0_0000_000C, 64'h0100,                 1'b0, 64'h0,                    64'h0,                    1'b0, 1'b0, 64'h0,                    1'b1};
        vecs[8] = '{36'h0_0000_0002, 64'h0200,                 1'b1, 64'h99,                   64'hBEEF,                 1'b0, 1'b1, 64'hBEEF,                 1'b0};
        vecs[9] = '{36'hF_FFFF_FFFF, 64'h1_0FFF,               1'b0, 64'h0,                    64'hFEED_FACE_0123_4567,  1'b0, 1'b1, 64'hFEED_FACE_0123_4567,  1'b0};

        rst_i        = 1'b1;
        acc_ctrl     = '0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_we       = 1'b0;
        req_wdata    = '0;
        dn_req_ready = 1'b0;
        dn_rsp_valid = 1'b0;
        dn_rsp_rdata = '0;
        dn_rsp_err   = 1'b0;
        rsp_ready    = 1'b0;
        exp_cnt      = 16'd0;
        exp_vaddr    = '0;

        // Reset state
        @(negedge clk);
        #1;
        chk("reset_cycle_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("rst_ready", 64'(req_ready), 64'(1));
        chk("rst_dn_valid", 64'(dn_req_valid), 64'(0));
        chk("rst_dn_addr", dn_addr, 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_rsp_rdata", rsp_rdata, 64'(0));
        chk("rst_viol", 64'(viol), 64'(0));
        chk("rst_viol_cnt", 64'(viol_cnt), 64'(0));
        chk("rst_viol_addr", viol_addr, 64'(0));

        // Table-driven transactions
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            run_txn(vecs[i], 0);
        end

        // Long downstream stall with permissions withdrawn mid-flight
        tmp = '{36'hF_FFFF_FFFF, 64'h5018, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h42, 1'b0, 1'b1, 64'h42, 1'b0};
        @(negedge clk);
        run_txn(tmp, 5);

        // No acceptance in the cycle the upstream response handshakes
        @(negedge clk);
        acc_ctrl  = '0;
        req_valid = 1'b1;
        req_addr  = 64'h1000;
        #1;
        chk("b2b_accept", 64'(req_ready), 64'(1));
        @(negedge clk);
        #1;
        chk("b2b_deny1_viol", 64'(viol), 64'(1));
        count_denial(64'h1000);
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("b2b_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("b2b_rsp_ready_low", 64'(req_ready), 64'(0));
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("b2b_idle_ready", 64'(req_ready), 64'(1));
        chk("b2b_no_early_viol", 64'(viol), 64'(0));
        chk("b2b_no_rsp", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = '0;
        #1;
        chk("b2b_deny2_viol", 64'(viol), 64'(1));
        count_denial(64'h1000);
        @(negedge clk);
        #1;
        chk("b2b_rsp2_err", 64'(rsp_err), 64'(1));
        chk("b2b_viol_cnt", 64'(viol_cnt), 64'(exp_cnt));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset while waiting for the downstream response
        acc_ctrl  = '1;
        req_valid = 1'b1;
        req_addr  = 64'h4000;
        @(negedge clk);
        req_valid    = 1'b0;
        req_addr     = '0;
        dn_req_ready = 1'b1;
        #1;
        chk("mid_fwd_valid", 64'(dn_req_valid), 64'(1));
        @(negedge clk);
        dn_req_ready = 1'b0;
        rst_i        = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst_i        = 1'b0;
        dn_rsp_valid = 1'b1;
        dn_rsp_rdata = 64'h55;
        exp_cnt      = 16'd0;
        exp_vaddr    = '0;
        #1;
        chk("mid_ready", 64'(req_ready), 64'(1));
        chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rsp_rdata", rsp_rdata, 64'(0));
        chk("mid_dn_valid", 64'(dn_req_valid), 64'(0));
        chk("mid_viol_cnt", 64'(viol_cnt), 64'(0));
        chk("mid_viol_addr", viol_addr, 64'(0));
        @(negedge clk);
        dn_rsp_valid = 1'b0;
        dn_rsp_rdata = '0;
        #1;
        chk("mid_dropped_rsp", 64'(rsp_valid), 64'(0));
        run_txn(vecs[0], 1);

        // Counter saturation, starting from a preloaded count one short of the limit
        @(negedge clk);
        force dut.viol_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.viol_cnt_q;
        exp_cnt = 16'hFFFE;
        #1;
        chk("preload_cnt", 64'(viol_cnt), 64'(16'hFFFE));
        run_txn(vecs[3], 0);
        @(negedge clk);
        run_txn(vecs[4], 0);
        chk("sat_cnt", 64'(viol_cnt), 64'(16'hFFFF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
